// File: rtl/rx_os_pkg.sv
// Shared constants for the RX ordered-set sequencer: symbol codes, FSM encoding
// and the legal link-configuration set.
package rx_os_pkg;

    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;
    localparam logic [7:0] SKP_ID = 8'h1C;

    localparam int MAX_LANES = 16;
    localparam int LANE_BITS = 128;

    // Bit n set means a lane count of n is legal: 1, 2, 4, 8, 16.
    localparam logic [31:0] LEGAL_LANE_MASK = 32'h0001_0116;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONFIG = 2'd1,
        RUN    = 2'd2
    } state_t;

    function automatic logic cfg_legal(input logic [2:0] gen, input logic [4:0] lanes);
        return (gen != 3'd0) && (gen <= 3'd5) && LEGAL_LANE_MASK[lanes];
    endfunction

endpackage

// File: rtl/os_ts_counter.sv
// Saturating consecutive-TS counter with a sticky threshold flag.
// Priority: clr_all (count and flag) > hold > clr > inc; one-cycle update.
module os_ts_counter #(
    parameter int CNT_W     = 4,
    parameter int TS_THRESH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    input  logic             i_hold,
    input  logic             i_clr_all,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   THRESH  = (CNT_W+1)'(TS_THRESH);

    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_clr_all) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_hold) begin
            r_cnt  <= r_cnt;
        end else if (i_clr) begin
            r_cnt  <= '0;
        end else if (i_inc) begin
            r_cnt  <= w_cnt_inc;
            if ({1'b0, w_cnt_inc} >= THRESH)
                r_done <= 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_done = r_done;

endmodule

// File: rtl/rx_os_sequencer.sv
// RX ordered-set sequencer: config latch, decoder enable FSM and TS1/TS2 run counting.
// Define OS_SKP_FILTER_EN to let SKP ordered sets pass without breaking a TS run.
module rx_os_sequencer
    import rx_os_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int TS_THRESH     = 8,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfgReq,
    input  logic [2:0]       cfgGen,
    input  logic [4:0]       cfgLanes,
    output logic             cfgAck,
    output logic             cfgErr,
    input  logic             lmcValid,
    input  logic             linkUp,
    output logic [2:0]       decGen,
    output logic [4:0]       decLanes,
    output logic             decValid,
    input  logic             osValid,
    input  logic [2047:0]    outOs,
    output logic [CNT_W-1:0] ts1Count,
    output logic [CNT_W-1:0] ts2Count,
    output logic             ts1Done,
    output logic             ts2Done,
    output logic [1:0]       state
);

    state_t     r_state;
    logic [2:0] r_gen;
    logic [4:0] r_lanes;
    logic [3:0] r_settle;
    logic       r_dec_valid;
    logic       r_ack;
    logic       r_err;

    logic w_cfg_ok;
    logic w_is_ts1;
    logic w_is_ts2;
    logic w_is_skp;
    logic w_os_take;
    logic w_link_drop;
    logic w_skp_hold;
    logic w_os_unused;

    assign w_cfg_ok    = cfgReq && cfg_legal(cfgGen, cfgLanes);
    assign w_os_take   = (r_state == RUN) && osValid && linkUp && !cfgReq;
    assign w_link_drop = (r_state == RUN) && !linkUp && !w_cfg_ok;
    assign w_os_unused = ^outOs;

    // Lanes at or above the configured width never veto a match.
    always_comb begin
        w_is_ts1 = 1'b1;
        w_is_ts2 = 1'b1;
        w_is_skp = 1'b1;
        for (int k = 0; k < MAX_LANES; k++) begin
            if (5'(k) < r_lanes) begin
                if (outOs[k*LANE_BITS +: 8] != COM) begin
                    w_is_ts1 = 1'b0;
                    w_is_ts2 = 1'b0;
                    w_is_skp = 1'b0;
                end
                if (outOs[k*LANE_BITS + 48 +: 8] != TS1_ID) w_is_ts1 = 1'b0;
                if (outOs[k*LANE_BITS + 48 +: 8] != TS2_ID) w_is_ts2 = 1'b0;
                if (outOs[k*LANE_BITS + 8 +: 8]  != SKP_ID) w_is_skp = 1'b0;
            end
        end
    end

`ifdef OS_SKP_FILTER_EN
    assign w_skp_hold = w_os_take && w_is_skp && !w_is_ts1 && !w_is_ts2;
`else
    assign w_skp_hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_gen       <= 3'd1;
            r_lanes     <= 5'd1;
            r_settle    <= 4'd0;
            r_dec_valid <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_dec_valid <= 1'b0;
            if (w_cfg_ok) begin
                r_ack    <= 1'b1;
                r_gen    <= cfgGen;
                r_lanes  <= cfgLanes;
                r_settle <= 4'(SETTLE_CYCLES);
                r_state  <= CONFIG;
            end else begin
                r_err <= cfgReq;
                case (r_state)
                    IDLE: begin
                        // Reset defaults are a valid config, so link-up alone starts RUN.
                        if (linkUp)
                            r_state <= RUN;
                    end
                    CONFIG: begin
                        r_settle <= r_settle - 4'd1;
                        if (r_settle <= 4'd1)
                            r_state <= linkUp ? RUN : IDLE;
                    end
                    RUN: begin
                        if (!linkUp)
                            r_state <= IDLE;
                        else
                            r_dec_valid <= lmcValid;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    os_ts_counter #(.CNT_W(CNT_W), .TS_THRESH(TS_THRESH)) u_ts1_cnt (
        .clk       (clk),
        .reset     (reset),
        .i_inc     (w_os_take && w_is_ts1),
        .i_clr     (w_link_drop || (w_os_take && !w_is_ts1)),
        .i_hold    (w_skp_hold),
        .i_clr_all (w_cfg_ok),
        .o_cnt     (ts1Count),
        .o_done    (ts1Done)
    );

    os_ts_counter #(.CNT_W(CNT_W), .TS_THRESH(TS_THRESH)) u_ts2_cnt (
        .clk       (clk),
        .reset     (reset),
        .i_inc     (w_os_take && w_is_ts2 && !w_is_ts1),
        .i_clr     (w_link_drop || (w_os_take && !(w_is_ts2 && !w_is_ts1))),
        .i_hold    (w_skp_hold),
        .i_clr_all (w_cfg_ok),
        .o_cnt     (ts2Count),
        .o_done    (ts2Done)
    );

    assign cfgAck   = r_ack;
    assign cfgErr   = r_err;
    assign decGen   = r_gen;
    assign decLanes = r_lanes;
    assign decValid = r_dec_valid;
    assign state    = r_state;

endmodule

// File: tb/tb_rx_os_sequencer.sv
// Directed bench for rx_os_sequencer with a scoreboard of expected counter states.
// Build with OS_SKP_FILTER_EN defined to exercise the SKP-spanning variant.
module tb_rx_os_sequencer;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfgReq;
    logic [2:0]    cfgGen;
    logic [4:0]    cfgLanes;
    logic          cfgAck;
    logic          cfgErr;
    logic          lmcValid;
    logic          linkUp;
    logic [2:0]    decGen;
    logic [4:0]    decLanes;
    logic          decValid;
    logic          osValid;
    logic [2047:0] outOs;
    logic [3:0]    ts1Count;
    logic [3:0]    ts2Count;
    logic          ts1Done;
    logic          ts2Done;
    logic [1:0]    state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the counters and the expected configuration.
    logic [3:0] m1 = 4'd0;
    logic [3:0] m2 = 4'd0;
    logic       d1 = 1'b0;
    logic       d2 = 1'b0;
    logic [2:0] cur_gen   = 3'd1;
    logic [4:0] cur_lanes = 5'd1;
    logic [9:0] sb[$];

    localparam int K_OTHER = 0;
    localparam int K_TS1   = 1;
    localparam int K_TS2   = 2;
    localparam int K_SKP   = 3;

    rx_os_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .cfgReq   (cfgReq),
        .cfgGen   (cfgGen),
        .cfgLanes (cfgLanes),
        .cfgAck   (cfgAck),
        .cfgErr   (cfgErr),
        .lmcValid (lmcValid),
        .linkUp   (linkUp),
        .decGen   (decGen),
        .decLanes (decLanes),
        .decValid (decValid),
        .osValid  (osValid),
        .outOs    (outOs),
        .ts1Count (ts1Count),
        .ts2Count (ts2Count),
        .ts1Done  (ts1Done),
        .ts2Done  (ts2Done),
        .state    (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2047:0] make_os(input int kind, input logic [4:0] lanes);
        logic [2047:0] r;
        for (int w = 0; w < 64; w++) r[w*32 +: 32] = $urandom;
        for (int k = 0; k < 16; k++) begin
            if (k < int'(lanes)) begin
                case (kind)
                    K_TS1: begin r[k*128 +: 8] = 8'hBC; r[k*128+48 +: 8] = 8'h4A; end
                    K_TS2: begin r[k*128 +: 8] = 8'hBC; r[k*128+48 +: 8] = 8'h45; end
                    K_SKP: begin
                        r[k*128 +: 8] = 8'hBC; r[k*128+8 +: 8] = 8'h1C; r[k*128+48 +: 8] = 8'h00;
                    end
                    default: r[k*128 +: 8] = 8'h00;
                endcase
            end
        end
        return r;
    endfunction

    task automatic model_os(input int kind);
        case (kind)
            K_TS1: begin
                if (m1 != 4'hF) m1 = m1 + 4'd1;
                m2 = 4'd0;
                if (m1 >= 4'd8) d1 = 1'b1;
            end
            K_TS2: begin
                if (m2 != 4'hF) m2 = m2 + 4'd1;
                m1 = 4'd0;
                if (m2 >= 4'd8) d2 = 1'b1;
            end
            K_SKP: begin
`ifndef OS_SKP_FILTER_EN
                m1 = 4'd0;
                m2 = 4'd0;
`endif
            end
            default: begin m1 = 4'd0; m2 = 4'd0; end
        endcase
    endtask

    // Drive one ordered set; eff says whether the DUT should act on it.
    task automatic apply_os(input int kind, input int bad_lane, input bit eff, input string tag);
        logic [9:0] e;
        outOs = make_os(kind, cur_lanes);
        if (bad_lane >= 0) outOs[bad_lane*128+48 +: 8] = 8'h45;
        osValid = 1'b1;
        if (eff) model_os(kind);
        sb.push_back({d1, d2, m1, m2});
        step();
        osValid = 1'b0;
        e = sb.pop_front();
        check({tag, "_ts1cnt"},  32'(ts1Count), 32'(e[7:4]));
        check({tag, "_ts2cnt"},  32'(ts2Count), 32'(e[3:0]));
        check({tag, "_ts1done"}, 32'(ts1Done),  32'(e[9]));
        check({tag, "_ts2done"}, 32'(ts2Done),  32'(e[8]));
    endtask

    task automatic do_cfg(input logic [2:0] g, input logic [4:0] l, input bit legal, input string tag);
        cfgGen = g; cfgLanes = l; cfgReq = 1'b1;
        if (legal) begin
            m1 = 4'd0; m2 = 4'd0; d1 = 1'b0; d2 = 1'b0;
            cur_gen = g; cur_lanes = l;
        end
        step();
        cfgReq = 1'b0;
        check({tag, "_ack"},    32'(cfgAck),   32'(legal));
        check({tag, "_err"},    32'(cfgErr),   32'(!legal));
        check({tag, "_gen"},    32'(decGen),   32'(cur_gen));
        check({tag, "_lanes"},  32'(decLanes), 32'(cur_lanes));
        check({tag, "_ts1cnt"}, 32'(ts1Count), 32'(m1));
        check({tag, "_ts2cnt"}, 32'(ts2Count), 32'(m2));
        if (legal) check({tag, "_state"}, 32'(state), 32'd1);
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (state !== 2'd2 && n < 20) begin
            step();
            n++;
        end
        check(tag, 32'(state), 32'd2);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"},  32'(state),    32'd0);
        check({tag, "_gen"},    32'(decGen),   32'd1);
        check({tag, "_lanes"},  32'(decLanes), 32'd1);
        check({tag, "_dvalid"}, 32'(decValid), 32'd0);
        check({tag, "_ack"},    32'(cfgAck),   32'd0);
        check({tag, "_err"},    32'(cfgErr),   32'd0);
        check({tag, "_counts"}, 32'({ts1Count, ts2Count}), 32'd0);
        check({tag, "_done"},   32'({ts1Done, ts2Done}),   32'd0);
    endtask

    initial begin
        logic [3:0] exp_skp_cnt;
        logic       exp_skp_done;
`ifdef OS_SKP_FILTER_EN
        exp_skp_cnt = 4'd8; exp_skp_done = 1'b1;
`else
        exp_skp_cnt = 4'd5; exp_skp_done = 1'b0;
`endif
        reset = 1'b0; cfgReq = 1'b0; cfgGen = 3'd0; cfgLanes = 5'd0;
        lmcValid = 1'b0; linkUp = 1'b0; osValid = 1'b0; outOs = '0;
        #12;
        check_reset_vals("por");

        // First config issued in the same cycle link comes up: config wins over IDLE->RUN.
        reset = 1'b1; linkUp = 1'b1;
        do_cfg(3'd1, 5'd2, 1'b1, "cfg1");
        lmcValid = 1'b1;
        check("cfg1_dvalid_c0", 32'(decValid), 32'd0);
        for (int i = 1; i < 4; i++) begin
            step();
            check($sformatf("settle%0d_state", i), 32'(state), 32'd1);
            check($sformatf("settle%0d_dvalid", i), 32'(decValid), 32'd0);
            check($sformatf("settle%0d_ack", i), 32'(cfgAck), 32'd0);
        end
        step();
        check("run_entry_state", 32'(state), 32'd2);
        check("run_entry_dvalid", 32'(decValid), 32'd0);
        step();
        check("dvalid_follow_hi", 32'(decValid), 32'd1);
        lmcValid = 1'b0;
        step();
        check("dvalid_follow_lo", 32'(decValid), 32'd0);
        lmcValid = 1'b1;

        // Eight TS1 reach the threshold; a TS2 breaks the run but the flag sticks.
        for (int i = 0; i < 8; i++) apply_os(K_TS1, -1, 1'b1, $sformatf("x2_ts1_%0d", i));
        apply_os(K_TS2, -1, 1'b1, "x2_ts2");

        do_cfg(3'd3, 5'd4, 1'b1, "cfg4");
        apply_os(K_TS1, -1, 1'b0, "cfg4_settle_os");
        wait_run("cfg4_run");
        apply_os(K_TS1, -1, 1'b1, "x4_ts1_a");
        apply_os(K_TS1, -1, 1'b1, "x4_ts1_b");
        apply_os(K_OTHER, 3, 1'b1, "x4_lane3_bad");
        apply_os(K_TS1, -1, 1'b1, "x4_upper_garbage");

        do_cfg(3'd2, 5'd3, 1'b0, "bad_lanes");
        step();
        check("err_pulse_clears", 32'(cfgErr), 32'd0);
        do_cfg(3'd6, 5'd4, 1'b0, "bad_gen");
        do_cfg(3'd0, 5'd1, 1'b0, "bad_gen0");
        check("bad_cfg_state", 32'(state), 32'd2);

        apply_os(K_OTHER, -1, 1'b1, "skp_pre_clear");
        for (int i = 0; i < 3; i++) apply_os(K_TS1, -1, 1'b1, $sformatf("skp_ts1a_%0d", i));
        apply_os(K_SKP, -1, 1'b1, "skp_mid");
        for (int i = 0; i < 5; i++) apply_os(K_TS1, -1, 1'b1, $sformatf("skp_ts1b_%0d", i));
        check("skp_span_cnt", 32'(ts1Count), 32'(exp_skp_cnt));
        check("skp_span_done", 32'(ts1Done), 32'(exp_skp_done));

        // Config and os together: os is discarded.
        outOs = make_os(K_TS1, cur_lanes);
        osValid = 1'b1;
        do_cfg(3'd2, 5'd1, 1'b1, "cfg_vs_os");
        osValid = 1'b0;
        wait_run("cfg1l_run");

        for (int i = 0; i < 17; i++) apply_os(K_TS2, -1, 1'b1, $sformatf("sat_ts2_%0d", i));
        check("ts2_saturated", 32'(ts2Count), 32'd15);
        apply_os(K_TS1, -1, 1'b1, "sat_break");
        for (int i = 0; i < 5; i++) apply_os(K_TS2, -1, 1'b1, $sformatf("drop_ts2_%0d", i));

        linkUp = 1'b0;
        m1 = 4'd0; m2 = 4'd0;
        step();
        check("drop_state", 32'(state), 32'd0);
        check("drop_dvalid", 32'(decValid), 32'd0);
        check("drop_counts", 32'({ts1Count, ts2Count}), 32'd0);
        check("drop_ts2done_held", 32'(ts2Done), 32'd1);
        apply_os(K_TS2, -1, 1'b0, "idle_os_ignored");

        linkUp = 1'b1;
        step();
        check("relink_state", 32'(state), 32'd2);
        apply_os(K_TS1, -1, 1'b1, "relink_ts1_a");
        apply_os(K_TS1, -1, 1'b1, "relink_ts1_b");

        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("async_rst");
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rx_os_sequencer.md
Name: rx_os_sequencer

Overview:
- Controls the RX ordered-set decoder and sits between the lane-management (LMC) logic, the decoder and the RX LTSSM.
- Latches link configuration (generation, detected lane count) and drives it to the decoder. Sequences decoder enable through IDLE/CONFIG/RUN, with a settle window after every reconfiguration.
- Classifies each decoded ordered set as TS1, TS2 or other across all active lanes. Keeps saturating consecutive-TS counters that the LTSSM uses for state exit.

Parameters:
- SETTLE_CYCLES, 4: cycles decValid is held low after a config is applied (valid 1..15).
- TS_THRESH, 8: consecutive identical TS count that sets tsXDone.
- CNT_W, 4: width of consecutive counters; counters saturate at 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cfgReq  in  1  single-cycle request to apply cfgGen/cfgLanes
- cfgGen  in  3  requested generation, 1..5
- cfgLanes  in  5  requested lane count, one of 1,2,4,8,16
- cfgAck  out  1  pulse: config accepted
- cfgErr  out  1  pulse: config rejected
- lmcValid  in  1  data-valid from lane management
- linkUp  in  1  link-up indication
- decGen  out  3  generation driven to decoder
- decLanes  out  5  lane count driven to decoder
- decValid  out  1  gated valid to decoder
- osValid  in  1  decoder output-valid
- outOs  in  2048  decoded ordered sets; lane k, symbol s at [k*128 + s*8 +: 8]
- ts1Count  out  CNT_W  consecutive TS1 count
- ts2Count  out  CNT_W  consecutive TS2 count
- ts1Done  out  1  sticky: ts1Count >= TS_THRESH
- ts2Done  out  1  sticky: ts2Count >= TS_THRESH
- state  out  2  FSM state, for debug

Behaviour:
- Reset (async, reset=0) values:
  - state=IDLE
  - decGen=3'd1, decLanes=5'd1
  - decValid=0, cfgAck=0, cfgErr=0
  - counters=0, Done flags=0
- FSM encoding: IDLE=0, CONFIG=1, RUN=2.
- cfgReq validation, in any state:
  - Legal: cfgGen in 1..5 and cfgLanes in {1,2,4,8,16}.
  - Legal request: next cycle cfgAck=1, decGen/decLanes updated, counters and Done flags cleared, state=CONFIG, settle counter loaded with SETTLE_CYCLES.
  - Illegal request: next cycle cfgErr=1. State, config and counters are unchanged.
- CONFIG: decValid=0. The settle counter decrements each cycle. On reaching 0, go to RUN if linkUp=1, else IDLE.
- IDLE: decValid=0. Go to RUN when linkUp=1 and at least one config has been accepted since reset. The reset defaults count as accepted.
- RUN: decValid is a registered copy of (lmcValid & linkUp), so 1-cycle latency. linkUp=0 in RUN means next state IDLE, decValid=0, counters cleared, Done flags held.
- Classification, combinational on outOs, sampled only when osValid=1 in RUN:
  - TS1: every active lane k < decLanes has symbol0=8'hBC and symbol6=8'h4A.
  - TS2: same condition with symbol6=8'h45.
  - SKP: every active lane has symbol0=8'hBC and symbol1=8'h1C.
  - Other: anything else. Inactive lanes are ignored.
- Counter updates, taking effect the next cycle:
  - TS1: ts1Count+1 (saturating), ts2Count=0.
  - TS2: ts2Count+1 (saturating), ts1Count=0.
  - Other: both counters cleared.
  - SKP: see Optional Feature.
  - tsXDone sets in the same cycle tsXCount is written to a value >= TS_THRESH. It clears only on reset or on an accepted cfg.
- Simultaneous cfgReq and osValid: the cfg wins and the os is discarded.
- osValid outside RUN is ignored.
- Reset mid-operation returns immediately to the reset values.

Optional Feature:
- Macro OS_SKP_FILTER_EN.
- Defined: SKP ordered sets leave both counters unchanged, so consecutive TS counting spans SKP insertion.
- Undefined: SKP is classified as Other and clears both counters.

Decomposition:
- Package rx_os_pkg holds:
  - symbol constants COM=8'hBC, TS1_ID=8'h4A, TS2_ID=8'h45, SKP_ID=8'h1C
  - state encoding IDLE/CONFIG/RUN
  - the legal lane-count set
- One sub-module, os_ts_counter: saturating consecutive counter with inc/clr/hold inputs plus a threshold-sticky flag. It is instantiated twice, for TS1 and TS2.

Test Plan:
- Reset release, linkUp=1, cfgReq gen=1 lanes=2 -> cfgAck next cycle, decLanes=2, decValid=0 for 4 cycles, then RUN and decValid follows lmcValid with 1-cycle lag.
- RUN x2: 8 osValid TS1 (lane0/1 symbol6=4A) -> ts1Count=8, ts1Done=1 on the 8th update. Then one TS2 -> ts1Count=0, ts2Count=1, ts1Done still 1.
- x4: TS1 with lane 3 symbol6=45 -> classified Other, both counts 0. Lanes 4..15 garbage while lanes 0..3 are valid TS1 -> counted.
- cfgReq lanes=3 -> cfgErr pulse, decLanes unchanged, counts unchanged. cfgReq gen=6 lanes=4 -> cfgErr pulse.
- TS1 x3, SKP, TS1 x5 -> with OS_SKP_FILTER_EN ts1Count=8 and ts1Done=1; without it ts1Count=5 and ts1Done=0.
- linkUp drops in RUN with ts2Count=5 -> IDLE next cycle, counts 0, decValid 0. Async reset asserted mid-RUN -> all outputs return to reset values immediately.
